// File: rtl/fwd_agent.sv
// Forwarder agent: accepts a buffer grant from the p3 controller, reads the packet
// out of the packet buffer and streams it as valid/ready/last beats, then reports done.
module fwd_agent #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned PLEN_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_for_fwd,
    output logic                  rdy_for_fwd_ack,
    output logic                  fwd_done,
    input  logic                  fwd_done_ack,
    input  logic [PLEN_WIDTH-1:0] plen,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tvalid,
    output logic                  out_tlast,
    input  logic                  out_tready
);

    localparam int unsigned SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int unsigned CW    = (PLEN_WIDTH > ADDR_WIDTH) ? PLEN_WIDTH : ADDR_WIDTH;
    localparam logic [PLEN_WIDTH-1:0] LOW_MASK = PLEN_WIDTH'((64'd1 << SHIFT) - 64'd1);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e                state_q;
    logic [CW-1:0]         nbeats_q;
    logic [CW-1:0]         rd_cnt_q;
    logic [CW-1:0]         out_cnt_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wptr_q;
    logic                  rptr_q;
    logic [1:0]            count_q;

    logic [CW-1:0] nbeats_c;
    logic [1:0]    occupancy;
    logic          pop;
    logic          pop_fifo;
    logic          push;

    // Round the byte length up to whole beats without a divider.
    assign nbeats_c = CW'(plen >> SHIFT) + CW'(|(plen & LOW_MASK));

    assign rdy_for_fwd_ack = rst && (state_q == StIdle) && rdy_for_fwd;
    assign fwd_done        = (state_q == StDone);

    assign occupancy = count_q + 2'(inflight_q);
    assign rd_en     = (state_q == StStream) && (rd_cnt_q < nbeats_q) && (occupancy < 2'd2);
    assign rd_addr   = rd_cnt_q[ADDR_WIDTH-1:0];

    // A word returning into an empty FIFO is presented straight away; if it is not
    // accepted it is stored, so the head stays stable on the next cycle.
    assign out_tvalid = (count_q != 2'd0) || inflight_q;
    assign out_tdata  = ((count_q == 2'd0) && inflight_q) ? rd_data : mem_q[rptr_q];
    assign out_tlast  = out_tvalid && (out_cnt_q == nbeats_q - CW'(1));

    assign pop      = out_tvalid && out_tready;
    assign pop_fifo = pop && (count_q != 2'd0);
    assign push     = inflight_q && !((count_q == 2'd0) && pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            nbeats_q   <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= rd_en;
            if (rd_en) begin
                rd_cnt_q <= rd_cnt_q + CW'(1);
            end
            if (push) begin
                mem_q[wptr_q] <= rd_data;
                wptr_q        <= ~wptr_q;
            end
            if (pop_fifo) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop_fifo);
            if (pop) begin
                out_cnt_q <= out_cnt_q + CW'(1);
            end

            case (state_q)
                StIdle: begin
                    if (rdy_for_fwd_ack) begin
                        nbeats_q  <= nbeats_c;
                        rd_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        state_q   <= (plen == '0) ? StDone : StStream;
                    end
                end
                StStream: begin
                    if (pop && out_tlast) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (fwd_done_ack) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fwd_agent.sv
// Bench for fwd_agent: packet-level model checked every cycle, plus directed
// cycle-exact expectations per scenario.
module tb_fwd_agent;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy_for_fwd;
    logic          rdy_for_fwd_ack;
    logic          fwd_done;
    logic          fwd_done_ack;
    logic [PW-1:0] plen;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tlast;
    logic          out_tready;
    logic [15:0]   tag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fwd_agent #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .PLEN_WIDTH(PW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy_for_fwd    (rdy_for_fwd),
        .rdy_for_fwd_ack(rdy_for_fwd_ack),
        .fwd_done       (fwd_done),
        .fwd_done_ack   (fwd_done_ack),
        .plen           (plen),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .out_tdata      (out_tdata),
        .out_tvalid     (out_tvalid),
        .out_tlast      (out_tlast),
        .out_tready     (out_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Packet buffer: word content encodes the packet tag and the word address.
    always @(posedge clk) begin
        if (rd_en) rd_data <= {tag, 7'b0, rd_addr};
    end

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endfunction

    function automatic void check_q(string name, int got[$], int exp[$]);
        chk({name, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            chk(name, 64'(got[i]), 64'(exp[i]));
        end
    endfunction

    // Event logs (cycle numbers) filled by the monitor.
    int ack_log[$];
    int rd_log[$];
    int addr_log[$];
    int beat_log[$];
    int last_log[$];
    int done_log[$];

    // Packet-level model state.
    bit          m_busy = 0;
    int          m_nb = 0;
    int          m_rd = 0;
    int          m_acc = 0;
    logic [15:0] m_tag = '0;
    bit          hold_v = 0;
    logic [DW-1:0] hold_d = '0;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 0;
            m_nb   = 0;
            m_rd   = 0;
            m_acc  = 0;
            hold_v = 0;
        end else begin
            if (rdy_for_fwd_ack) begin
                chk("ack_needs_req", rdy_for_fwd, 1);
                chk("ack_when_free", m_busy, 0);
                ack_log.push_back(cyc);
                m_busy = 1;
                m_nb   = (int'(plen) + 3) / 4;
                m_rd   = 0;
                m_acc  = 0;
                m_tag  = tag;
            end
            if (rd_en) begin
                chk("rd_busy", m_busy, 1);
                chk("rd_addr", rd_addr, 64'(m_rd % 512));
                chk("rd_beyond_len", m_rd < m_nb, 1);
                chk("rd_occupancy", (m_rd - m_acc) < 2, 1);
                rd_log.push_back(cyc);
                addr_log.push_back(int'(rd_addr));
                m_rd++;
            end
            if (out_tvalid) begin
                chk("beat_busy", m_busy, 1);
                chk("beat_was_read", m_acc < m_rd, 1);
                chk("tdata", out_tdata, {m_tag, 16'(m_acc)});
                chk("tlast", out_tlast, m_acc == m_nb - 1);
                if (hold_v) chk("tdata_stable", out_tdata, hold_d);
                if (out_tready) begin
                    beat_log.push_back(cyc);
                    last_log.push_back(int'(out_tlast));
                    m_acc++;
                    hold_v = 0;
                end else begin
                    hold_v = 1;
                    hold_d = out_tdata;
                end
            end else if (hold_v) begin
                chk("tvalid_held", out_tvalid, 1);
                hold_v = 0;
            end
            if (fwd_done) begin
                chk("done_busy", m_busy, 1);
                chk("done_all_beats", 64'(m_acc), 64'(m_nb));
                done_log.push_back(cyc);
                if (fwd_done_ack) m_busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ack_log.delete();
        rd_log.delete();
        addr_log.delete();
        beat_log.delete();
        last_log.delete();
        done_log.delete();
    endtask

    task automatic check_zero(string pre);
        @(negedge clk);
        chk({pre, "_ack"}, rdy_for_fwd_ack, 0);
        chk({pre, "_done"}, fwd_done, 0);
        chk({pre, "_rd_en"}, rd_en, 0);
        chk({pre, "_rd_addr"}, rd_addr, 0);
        chk({pre, "_tdata"}, out_tdata, 0);
        chk({pre, "_tvalid"}, out_tvalid, 0);
        chk({pre, "_tlast"}, out_tlast, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int c;
        int e[$];
        int ea[$];
        bit pat[5];

        rst = 1'b0;
        rdy_for_fwd = 1'b0;
        fwd_done_ack = 1'b1;
        plen = '0;
        out_tready = 1'b1;
        tag = 16'h1111;
        repeat (3) tick();
        check_zero("reset");
        tick();
        rst = 1'b1;
        repeat (2) tick();

        // 10 bytes on a 4-byte bus: 3 beats back to back.
        clear_logs();
        tag = 16'h1A1A;
        plen = 12'd10;
        rdy_for_fwd = 1'b1;
        c = cyc;
        tick();
        rdy_for_fwd = 1'b0;
        repeat (8) tick();
        e = '{c};                check_q("t1_ack", ack_log, e);
        e = '{c+1, c+2, c+3};    check_q("t1_rd", rd_log, e);
        ea = '{0, 1, 2};         check_q("t1_addr", addr_log, ea);
        e = '{c+2, c+3, c+4};    check_q("t1_beat", beat_log, e);
        ea = '{0, 0, 1};         check_q("t1_last", last_log, ea);
        e = '{c+5};              check_q("t1_done", done_log, e);

        // Zero-length packet: straight to done.
        clear_logs();
        plen = 12'd0;
        rdy_for_fwd = 1'b1;
        c = cyc;
        tick();
        rdy_for_fwd = 1'b0;
        repeat (4) tick();
        e = '{c};    check_q("t2_ack", ack_log, e);
        e = {};      check_q("t2_rd", rd_log, e);
        e = {};      check_q("t2_beat", beat_log, e);
        e = '{c+1};  check_q("t2_done", done_log, e);

        // 16 bytes with backpressure 1,0,0,1,1.
        clear_logs();
        tag = 16'h3333;
        plen = 12'd16;
        rdy_for_fwd = 1'b1;
        c = cyc;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tick();
        rdy_for_fwd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            out_tready = pat[i];
        end
        tick();
        out_tready = 1'b1;
        repeat (5) tick();
        e = '{c+1, c+2, c+3, c+6};   check_q("t3_rd", rd_log, e);
        ea = '{0, 1, 2, 3};          check_q("t3_addr", addr_log, ea);
        e = '{c+2, c+5, c+6, c+7};   check_q("t3_beat", beat_log, e);
        ea = '{0, 0, 0, 1};          check_q("t3_last", last_log, ea);
        e = '{c+8};                  check_q("t3_done", done_log, e);

        // Done held for 5 cycles without ack while a new request waits.
        clear_logs();
        tag = 16'h4444;
        plen = 12'd4;
        rdy_for_fwd = 1'b1;
        c = cyc;
        tick();
        plen = 12'd0;
        fwd_done_ack = 1'b0;
        repeat (7) tick();
        fwd_done_ack = 1'b1;
        repeat (2) tick();
        rdy_for_fwd = 1'b0;
        repeat (3) tick();
        e = '{c, c+9};                                check_q("t4_ack", ack_log, e);
        e = '{c+2};                                   check_q("t4_beat", beat_log, e);
        e = '{c+3, c+4, c+5, c+6, c+7, c+8, c+10};    check_q("t4_done", done_log, e);

        // Reset in the middle of a 4-beat packet after one beat.
        clear_logs();
        tag = 16'h5555;
        plen = 12'd16;
        rdy_for_fwd = 1'b1;
        c = cyc;
        tick();
        rdy_for_fwd = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        out_tready = 1'b0;
        tick();
        rst = 1'b1;
        out_tready = 1'b1;
        check_zero("midrst");
        repeat (3) tick();
        e = '{c+1, c+2};   check_q("t5_rd", rd_log, e);
        e = '{c+2};        check_q("t5_beat", beat_log, e);
        e = {};            check_q("t5_done", done_log, e);
        clear_logs();
        tag = 16'h5A5A;
        plen = 12'd4;
        rdy_for_fwd = 1'b1;
        c = cyc;
        tick();
        rdy_for_fwd = 1'b0;
        repeat (5) tick();
        e = '{c};      check_q("t5b_ack", ack_log, e);
        e = '{c+1};    check_q("t5b_rd", rd_log, e);
        ea = '{0};     check_q("t5b_addr", addr_log, ea);
        e = '{c+2};    check_q("t5b_beat", beat_log, e);
        ea = '{1};     check_q("t5b_last", last_log, ea);
        e = '{c+3};    check_q("t5b_done", done_log, e);

        // Back-to-back grants, 8 bytes then 4 bytes.
        clear_logs();
        tag = 16'h6666;
        plen = 12'd8;
        rdy_for_fwd = 1'b1;
        c = cyc;
        tick();
        plen = 12'd4;
        repeat (5) tick();
        rdy_for_fwd = 1'b0;
        repeat (4) tick();
        e = '{c, c+5};          check_q("t6_ack", ack_log, e);
        e = '{c+1, c+2, c+6};   check_q("t6_rd", rd_log, e);
        ea = '{0, 1, 0};        check_q("t6_addr", addr_log, ea);
        e = '{c+2, c+3, c+7};   check_q("t6_beat", beat_log, e);
        ea = '{0, 1, 1};        check_q("t6_last", last_log, ea);
        e = '{c+4, c+8};        check_q("t6_done", done_log, e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_agent.md
Name: fwd_agent

Overview:
- Agent-side end of the packet-buffer ownership handshake for the forwarder (agent C).
- Waits for the p3 controller to grant a buffer, acknowledges the grant, reads the packet out of the granted buffer, and streams it as valid/ready/last beats.
- Reports done back to the controller so the buffer can be recycled to the snooper.
- Sits beside p3ctrl in each packetfilter_core; one instance per core.

Parameters:
- ADDR_WIDTH, 9: word address width of the packet buffer read port.
- DATA_WIDTH, 64: buffer word and output beat width in bits. Must be 8·2^k.
- PLEN_WIDTH, 12: width of the packet byte-length input.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- rdy_for_fwd  in  1  controller: a buffer is queued for forwarding (level).
- rdy_for_fwd_ack  out  1  grant accepted; 1-cycle pulse.
- fwd_done  out  1  forwarding finished; level until acked.
- fwd_done_ack  in  1  controller accepts done.
- plen  in  PLEN_WIDTH  byte length of the granted packet; valid in the ack cycle.
- rd_en  out  1  buffer read enable.
- rd_addr  out  ADDR_WIDTH  buffer word address.
- rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en.
- out_tdata  out  DATA_WIDTH  output beat.
- out_tvalid  out  1  beat valid.
- out_tlast  out  1  last beat of the packet.
- out_tready  in  1  downstream ready.

Behaviour:
- Reset (rst==0 at posedge) drives all of the following:
  - state=IDLE, all outputs 0 (including rd_addr and out_tdata).
  - Output FIFO flushed; any in-flight read discarded.
  - Reset mid-packet abandons the packet with no done issued.
- Grant handshake:
  - A grant transaction occurs in a cycle with rdy_for_fwd && rdy_for_fwd_ack.
  - rdy_for_fwd_ack is asserted combinationally only in IDLE while rdy_for_fwd=1, so it is high for at most one cycle per packet.
  - plen is sampled in that cycle.
- Beat count: nbeats = ceil(plen / (DATA_WIDTH/8)), computed with a shift plus an OR of the low bits. No divider.
- States:
  - IDLE → STREAM on a grant with plen≠0. Word counter rd_cnt=0, beat counter out_cnt=0.
  - IDLE → DONE on a grant with plen==0. No reads, no beats.
  - STREAM:
    - Issue rd_en with rd_addr=rd_cnt when rd_cnt<nbeats and (fifo_count + inflight) < 2. Increment rd_cnt on issue.
    - Read data returns one cycle later into the 2-entry output FIFO.
  - STREAM → DONE in the cycle after the beat with out_tvalid && out_tready && out_tlast.
  - DONE: fwd_done=1, held until fwd_done_ack=1. The done transaction is fwd_done && fwd_done_ack. Then → IDLE next cycle with fwd_done=0.
  - With fwd_done_ack tied high (current p3ctrl), fwd_done is a 1-cycle pulse.
- Output stream rules:
  - out_tvalid = FIFO non-empty. out_tdata = FIFO head.
  - out_tlast = 1 iff the head is beat nbeats-1.
  - Once out_tvalid rises, out_tdata and out_tvalid stay stable until the beat is accepted.
- Throughput: 1 beat/cycle with out_tready held high. First out_tvalid 2 cycles after the grant cycle.
- Backpressure: out_tready low blocks reads once FIFO plus in-flight reach 2. No overflow, no dropped words.
- Simultaneous events:
  - FIFO push and pop in the same cycle leave the count unchanged.
  - rdy_for_fwd is ignored outside IDLE.
  - A new grant is accepted no earlier than the cycle after the DONE→IDLE transition.
- Length overflow: nbeats > 2^ADDR_WIDTH is illegal. rd_addr wraps modulo 2^ADDR_WIDTH; no check is made.

Test Plan:
- DATA_WIDTH=32, rdy_for_fwd=1, plen=10, out_tready=1, fwd_done_ack=1:
  - ack for 1 cycle.
  - rd_addr 0,1,2.
  - 3 beats on consecutive cycles, tlast on the 3rd.
  - fwd_done for 1 cycle the next cycle.
- plen=0 grant → no rd_en, no out_tvalid, fwd_done the cycle after the ack.
- plen=16, out_tready toggling 1,0,0,1,1 → beats 0..3 in order, no duplicate or lost word, rd_en never issued with FIFO+inflight=2.
- fwd_done_ack held 0 for 5 cycles → fwd_done stays 1 for 5 cycles, rdy_for_fwd_ack stays 0 throughout, IDLE entered the cycle after the ack.
- rst=0 asserted mid-STREAM after 1 beat → next cycle all outputs 0 and no fwd_done; a subsequent grant with plen=4 streams 1 beat from rd_addr 0.
- Back-to-back grants (rdy_for_fwd stays 1) with plen=8 then plen=4 → second ack exactly 1 cycle after the first DONE→IDLE transition, and rd_addr restarts at 0.
